// File: rtl/sddr_pkg.sv
// ---------------------------------------------------------------------------
// sddr_pkg
// Shared definitions for the SDDR line buffer and its neighbours: the line
// buffer FSM state encoding, default geometry matching the controller, and
// helper functions that derive address/line widths from that geometry.
// ---------------------------------------------------------------------------
package sddr_pkg;

  // Default geometry; keep in step with the controller's parameters.
  localparam int DEFAULT_BANK_BITS    = 3;
  localparam int DEFAULT_ROW_BITS     = 13;
  localparam int DEFAULT_COL_BITS     = 10;
  localparam int DEFAULT_DATA_BITS    = 16;
  localparam int DEFAULT_BURST_LENGTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WB_REQ,
    ST_FILL_REQ,
    ST_FILL_WAIT,
    ST_FLUSH_WB,
    ST_RESPOND
  } lb_state_e;

  // Byte address width: bank + row + column + byte-within-DDR-word.
  function automatic int calc_address_bits(int bank_bits, int row_bits,
                                           int col_bits, int data_bits);
    return bank_bits + row_bits + col_bits + $clog2(data_bits / 8);
  endfunction

  // One whole burst forms one line.
  function automatic int calc_line_bits(int data_bits, int burst_length);
    return data_bits * burst_length;
  endfunction

  // Byte-offset bits within a line.
  function automatic int calc_ofs_bits(int line_bits);
    return $clog2(line_bits / 8);
  endfunction

  // Number of 32-bit CPU words per line.
  function automatic int calc_words(int line_bits);
    return line_bits / 32;
  endfunction

endpackage : sddr_pkg

// File: rtl/sddr_word_merge.sv
// ---------------------------------------------------------------------------
// sddr_word_merge
// Combinational byte-enable merge of one 32-bit word into a line.
//   line_i   : line before the operation
//   idx_i    : 32-bit word index within the line
//   wdata_i  : write data (byte b = wdata_i[8b+7:8b])
//   be_i     : byte enables; all-zero makes this a pure read
//   line_o   : line after the merge
//   word_o   : addressed word after the merge
// ---------------------------------------------------------------------------
module sddr_word_merge
  import sddr_pkg::*;
#(
  parameter int LINE_BITS = 128,
  parameter int IDX_BITS  = 2
) (
  input  logic [LINE_BITS-1:0] line_i,
  input  logic [IDX_BITS-1:0]  idx_i,
  input  logic [31:0]          wdata_i,
  input  logic [3:0]           be_i,
  output logic [LINE_BITS-1:0] line_o,
  output logic [31:0]          word_o
);

  localparam int WORDS = calc_words(LINE_BITS);

  always_comb begin
    // NOTE: every output gets a default before any conditional assignment,
    // so no path leaves a value held and no latch is inferred.
    line_o = line_i;
    word_o = '0;
    for (int w = 0; w < WORDS; w++) begin
      if (idx_i == w[IDX_BITS-1:0]) begin
        for (int b = 0; b < 4; b++) begin
          if (be_i[b]) begin
            line_o[32*w + 8*b +: 8] = wdata_i[8*b +: 8];
          end
        end
        word_o = line_o[32*w +: 32];
      end
    end
  end

endmodule : sddr_word_merge

// File: rtl/sddr_line_buffer.sv
// ---------------------------------------------------------------------------
// sddr_line_buffer
// Single-line write-back, write-allocate buffer between the CPU bus and the
// DDR controller's whole-line data port. One clock, async active-high reset.
//   cpu_req_*      : CPU word request (valid/ready), byte enables for writes
//   cpu_rsp_*      : one-cycle response pulse with the addressed word
//   flush_i        : level request to write back a dirty line and invalidate
//   flush_done_o   : one-cycle pulse when the flush has completed
//   data_cmd_*     : line command to the controller (valid/ack), held until ack
//   data_rsp_*     : fill data pulse from the controller
// ---------------------------------------------------------------------------
module sddr_line_buffer
  import sddr_pkg::*;
#(
  parameter  int BANK_BITS    = DEFAULT_BANK_BITS,
  parameter  int ROW_BITS     = DEFAULT_ROW_BITS,
  parameter  int COL_BITS     = DEFAULT_COL_BITS,
  parameter  int DATA_BITS    = DEFAULT_DATA_BITS,
  parameter  int BURST_LENGTH = DEFAULT_BURST_LENGTH,
  localparam int ADDRESS_BITS = calc_address_bits(BANK_BITS, ROW_BITS, COL_BITS, DATA_BITS),
  localparam int LINE_BITS    = calc_line_bits(DATA_BITS, BURST_LENGTH)
) (
  input  logic                    cpu_clock_i,
  input  logic                    reset_i,
  input  logic                    cpu_req_valid,
  output logic                    cpu_req_ready,
  input  logic [ADDRESS_BITS-1:0] cpu_req_addr,
  input  logic                    cpu_req_write,
  input  logic [31:0]             cpu_req_wdata,
  input  logic [3:0]              cpu_req_be,
  output logic                    cpu_rsp_valid,
  output logic [31:0]             cpu_rsp_data,
  input  logic                    flush_i,
  output logic                    flush_done_o,
  output logic                    data_cmd_valid,
  output logic [ADDRESS_BITS-1:0] data_cmd_address,
  output logic                    data_cmd_write,
  input  logic                    data_cmd_ack,
  output logic [LINE_BITS-1:0]    data_cmd_data_o,
  input  logic                    data_rsp_ready,
  input  logic [LINE_BITS-1:0]    data_rsp_data_i
);

  localparam int OFS_BITS = calc_ofs_bits(LINE_BITS);
  localparam int IDX_BITS = OFS_BITS - 2;
  localparam int TAG_BITS = ADDRESS_BITS - OFS_BITS;

  // Control state (reset)
  lb_state_e               state_q;
  logic                    valid_q;
  logic                    dirty_q;
  logic                    cmd_valid_q;
  logic [ADDRESS_BITS-1:0] cmd_addr_q;
  logic                    cmd_write_q;
  logic [LINE_BITS-1:0]    cmd_data_q;
  logic                    rsp_valid_q;
  logic [31:0]             rsp_data_q;
  logic                    flush_done_q;

  // Line storage and latched request (not reset)
  logic [LINE_BITS-1:0]    line_q;
  logic [TAG_BITS-1:0]     tag_q;
  logic [TAG_BITS-1:0]     lat_tag_q;
  logic [IDX_BITS-1:0]     lat_idx_q;
  logic                    lat_write_q;
  logic [31:0]             lat_wdata_q;
  logic [3:0]              lat_be_q;

  // Request decode
  logic [TAG_BITS-1:0]     req_tag;
  logic [IDX_BITS-1:0]     req_idx;
  logic                    req_fire;
  logic                    hit;
  logic                    unused_addr_bits;

  assign req_tag          = cpu_req_addr[ADDRESS_BITS-1:OFS_BITS];
  assign req_idx          = cpu_req_addr[OFS_BITS-1:2];
  assign unused_addr_bits = ^cpu_req_addr[1:0];
  assign hit              = valid_q && (tag_q == req_tag);

  // Ready is also gated by reset so every output reads 0 while reset is held.
  assign cpu_req_ready = (state_q == ST_IDLE) && !flush_i && !reset_i;
  assign req_fire      = cpu_req_valid && cpu_req_ready;

  // Merge datapath: a hit operates on the resident line with the live
  // request; a fill operates on the incoming line with the latched request.
  logic                 fill_mode;
  logic [LINE_BITS-1:0] m_line;
  logic [IDX_BITS-1:0]  m_idx;
  logic [31:0]          m_wdata;
  logic [3:0]           m_be;
  logic [LINE_BITS-1:0] merged_line;
  logic [31:0]          merged_word;
  logic                 hit_we;
  logic                 fill_we;

  always_comb begin
    fill_mode = (state_q == ST_FILL_WAIT);
    if (fill_mode) begin
      m_line  = data_rsp_data_i;
      m_idx   = lat_idx_q;
      m_wdata = lat_wdata_q;
      m_be    = lat_write_q ? lat_be_q : 4'b0000;
    end else begin
      m_line  = line_q;
      m_idx   = req_idx;
      m_wdata = cpu_req_wdata;
      m_be    = cpu_req_write ? cpu_req_be : 4'b0000;
    end
  end

  assign hit_we  = req_fire && hit && cpu_req_write;
  assign fill_we = fill_mode && data_rsp_ready;

  sddr_word_merge #(
    .LINE_BITS (LINE_BITS),
    .IDX_BITS  (IDX_BITS)
  ) u_word_merge (
    .line_i  (m_line),
    .idx_i   (m_idx),
    .wdata_i (m_wdata),
    .be_i    (m_be),
    .line_o  (merged_line),
    .word_o  (merged_word)
  );

  // NOTE: line and tag contents carry no reset; valid_q alone decides whether
  // they mean anything, so resetting the wide storage would buy nothing.
  always_ff @(posedge cpu_clock_i) begin
    if (req_fire) begin
      lat_tag_q   <= req_tag;
      lat_idx_q   <= req_idx;
      lat_write_q <= cpu_req_write;
      lat_wdata_q <= cpu_req_wdata;
      lat_be_q    <= cpu_req_be;
    end
    if (hit_we || fill_we) begin
      line_q <= merged_line;
    end
    if (fill_we) begin
      tag_q <= lat_tag_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge cpu_clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      valid_q      <= 1'b0;
      dirty_q      <= 1'b0;
      cmd_valid_q  <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_write_q  <= 1'b0;
      cmd_data_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      flush_done_q <= 1'b0;
    end else begin
      // Pulses default low and are raised only on their completion cycle.
      rsp_valid_q  <= 1'b0;
      flush_done_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (flush_i) begin
            if (valid_q && dirty_q) begin
              cmd_valid_q <= 1'b1;
              cmd_addr_q  <= {tag_q, {OFS_BITS{1'b0}}};
              cmd_write_q <= 1'b1;
              cmd_data_q  <= line_q;
              state_q     <= ST_FLUSH_WB;
            end else begin
              valid_q      <= 1'b0;
              flush_done_q <= 1'b1;
            end
          end else if (cpu_req_valid) begin
            if (hit) begin
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= merged_word;
              if (cpu_req_write) begin
                dirty_q <= 1'b1;
              end
              state_q <= ST_RESPOND;
            end else if (valid_q && dirty_q) begin
              cmd_valid_q <= 1'b1;
              cmd_addr_q  <= {tag_q, {OFS_BITS{1'b0}}};
              cmd_write_q <= 1'b1;
              cmd_data_q  <= line_q;
              state_q     <= ST_WB_REQ;
            end else begin
              cmd_valid_q <= 1'b1;
              cmd_addr_q  <= {req_tag, {OFS_BITS{1'b0}}};
              cmd_write_q <= 1'b0;
              state_q     <= ST_FILL_REQ;
            end
          end
        end

        // Write-back taken: the fill command follows on the very next cycle,
        // so cmd_valid_q stays high while address/direction change.
        ST_WB_REQ: begin
          if (data_cmd_ack) begin
            valid_q     <= 1'b0;
            dirty_q     <= 1'b0;
            cmd_addr_q  <= {lat_tag_q, {OFS_BITS{1'b0}}};
            cmd_write_q <= 1'b0;
            state_q     <= ST_FILL_REQ;
          end
        end

        ST_FILL_REQ: begin
          if (data_cmd_ack) begin
            cmd_valid_q <= 1'b0;
            state_q     <= ST_FILL_WAIT;
          end
        end

        ST_FILL_WAIT: begin
          if (data_rsp_ready) begin
            valid_q     <= 1'b1;
            dirty_q     <= lat_write_q;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= merged_word;
            state_q     <= ST_RESPOND;
          end
        end

        ST_FLUSH_WB: begin
          if (data_cmd_ack) begin
            cmd_valid_q  <= 1'b0;
            valid_q      <= 1'b0;
            dirty_q      <= 1'b0;
            flush_done_q <= 1'b1;
            state_q      <= ST_IDLE;
          end
        end

        ST_RESPOND: state_q <= ST_IDLE;

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cpu_rsp_valid    = rsp_valid_q;
  assign cpu_rsp_data     = rsp_data_q;
  assign flush_done_o     = flush_done_q;
  assign data_cmd_valid   = cmd_valid_q;
  assign data_cmd_address = cmd_addr_q;
  assign data_cmd_write   = cmd_write_q;
  assign data_cmd_data_o  = cmd_data_q;

endmodule : sddr_line_buffer

// File: tb/tb_sddr_line_buffer.sv
// ---------------------------------------------------------------------------
// tb_sddr_line_buffer
// Directed bench for sddr_line_buffer: expected CPU responses and controller
// commands are queued when stimulus is driven and checked by a monitor when
// the DUT produces them; cycle-exact timing is checked inline.
// ---------------------------------------------------------------------------
module tb_sddr_line_buffer;

  localparam int AW = 27;
  localparam int LW = 128;

  typedef struct {
    logic [AW-1:0] addr;
    logic          write;
    logic [LW-1:0] data;
  } cmd_t;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          cpu_req_valid;
  logic          cpu_req_ready;
  logic [AW-1:0] cpu_req_addr;
  logic          cpu_req_write;
  logic [31:0]   cpu_req_wdata;
  logic [3:0]    cpu_req_be;
  logic          cpu_rsp_valid;
  logic [31:0]   cpu_rsp_data;
  logic          flush_i;
  logic          flush_done_o;
  logic          data_cmd_valid;
  logic [AW-1:0] data_cmd_address;
  logic          data_cmd_write;
  logic          data_cmd_ack;
  logic [LW-1:0] data_cmd_data_o;
  logic          data_rsp_ready;
  logic [LW-1:0] data_rsp_data_i;

  always #5 clk = ~clk;

  sddr_line_buffer dut (
    .cpu_clock_i      (clk),
    .reset_i          (reset_i),
    .cpu_req_valid    (cpu_req_valid),
    .cpu_req_ready    (cpu_req_ready),
    .cpu_req_addr     (cpu_req_addr),
    .cpu_req_write    (cpu_req_write),
    .cpu_req_wdata    (cpu_req_wdata),
    .cpu_req_be       (cpu_req_be),
    .cpu_rsp_valid    (cpu_rsp_valid),
    .cpu_rsp_data     (cpu_rsp_data),
    .flush_i          (flush_i),
    .flush_done_o     (flush_done_o),
    .data_cmd_valid   (data_cmd_valid),
    .data_cmd_address (data_cmd_address),
    .data_cmd_write   (data_cmd_write),
    .data_cmd_ack     (data_cmd_ack),
    .data_cmd_data_o  (data_cmd_data_o),
    .data_rsp_ready   (data_rsp_ready),
    .data_rsp_data_i  (data_rsp_data_i)
  );

  int            n_checks    = 0;
  int            n_fail      = 0;
  int            n_cmds      = 0;
  int            exp_n_cmds  = 0;
  logic [31:0]   exp_rsp[$];
  cmd_t          exp_cmd[$];

  task automatic check(string tag, logic [LW-1:0] obs, logic [LW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(logic [AW-1:0] a, logic w, logic [LW-1:0] d);
    cmd_t c;
    c.addr  = a;
    c.write = w;
    c.data  = d;
    exp_cmd.push_back(c);
    exp_n_cmds++;
  endtask

  // Present a request in an idle cycle N; returns in cycle N+1.
  task automatic issue(logic [AW-1:0] a, logic w, logic [31:0] d, logic [3:0] be);
    cpu_req_addr  = a;
    cpu_req_write = w;
    cpu_req_wdata = d;
    cpu_req_be    = be;
    cpu_req_valid = 1'b1;
    #1 check("req_ready", cpu_req_ready, 1);
    step();
    cpu_req_valid = 1'b0;
  endtask

  // Wait (bounded) for a command, hold off 'delay' cycles, ack for one
  // cycle. Returns in the cycle after the ack.
  task automatic ack_cmd(int delay);
    int t = 0;
    while (!data_cmd_valid && t < 50) begin
      step();
      t++;
    end
    check("cmd_seen", data_cmd_valid, 1);
    repeat (delay) step();
    data_cmd_ack = 1'b1;
    step();
    data_cmd_ack = 1'b0;
  endtask

  // Deliver fill data for one cycle; the response must follow one cycle later.
  task automatic fill_rsp(logic [LW-1:0] line);
    data_rsp_data_i = line;
    data_rsp_ready  = 1'b1;
    step();
    data_rsp_ready  = 1'b0;
    check("rsp_after_fill", cpu_rsp_valid, 1);
    step();
    check("rsp_single_pulse", cpu_rsp_valid, 0);
  endtask

  // Monitor: scoreboard pops plus command-stability tracking.
  logic          hold_q = 1'b0;
  logic [AW-1:0] hold_addr;
  logic          hold_write;
  logic [LW-1:0] hold_data;

  always @(negedge clk) begin
    if (reset_i) begin
      hold_q = 1'b0;
    end else begin
      if (cpu_rsp_valid) begin
        check("rsp_expected", exp_rsp.size() != 0, 1);
        if (exp_rsp.size() != 0) check("rsp_data", cpu_rsp_data, exp_rsp.pop_front());
      end
      if (data_cmd_valid) begin
        if (hold_q) begin
          check("cmd_stable_addr", data_cmd_address, hold_addr);
          check("cmd_stable_write", data_cmd_write, hold_write);
          check("cmd_stable_data", data_cmd_data_o, hold_data);
        end
        if (data_cmd_ack) begin
          cmd_t e;
          n_cmds++;
          check("cmd_expected", exp_cmd.size() != 0, 1);
          if (exp_cmd.size() != 0) begin
            e = exp_cmd.pop_front();
            check("cmd_addr", data_cmd_address, e.addr);
            check("cmd_write", data_cmd_write, e.write);
            if (e.write) check("cmd_wb_data", data_cmd_data_o, e.data);
          end
        end
        hold_q     = !data_cmd_ack;
        hold_addr  = data_cmd_address;
        hold_write = data_cmd_write;
        hold_data  = data_cmd_data_o;
      end else begin
        if (hold_q) check("cmd_dropped_before_ack", data_cmd_valid, 1);
        hold_q = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  logic [LW-1:0] l1, l1m, l2, l2m, l3, l4, l5;

  initial begin
    l1  = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};
    l1m = {32'h33333333, 32'h22222222, 32'h11BB11DD, 32'h00000000};
    l2  = {32'hD3D3D3D3, 32'hC2C2C2C2, 32'hB1B1B1B1, 32'hA0A0A0A0};
    l2m = {32'hD3D3D3D3, 32'h12345678, 32'hB1B1B1B1, 32'hA0A0A0A0};
    l3  = {32'h3C3C3C3C, 32'h3B3B3B3B, 32'h3A3A3A3A, 32'h39393939};
    l4  = {32'h4D4D4D4D, 32'h4C4C4C4C, 32'h4B4B4B4B, 32'h4A4A4A4A};
    l5  = {32'h5D5D5D5D, 32'h5C5C5C5C, 32'h5B5B5B5B, 32'h5A5A5A5A};

    reset_i         = 1'b1;
    cpu_req_valid   = 1'b0;
    cpu_req_addr    = '0;
    cpu_req_write   = 1'b0;
    cpu_req_wdata   = '0;
    cpu_req_be      = '0;
    flush_i         = 1'b0;
    data_cmd_ack    = 1'b0;
    data_rsp_ready  = 1'b0;
    data_rsp_data_i = '0;

    // Reset state: all outputs low
    step();
    step();
    check("rst_req_ready", cpu_req_ready, 0);
    check("rst_rsp_valid", cpu_rsp_valid, 0);
    check("rst_flush_done", flush_done_o, 0);
    check("rst_cmd_valid", data_cmd_valid, 0);
    check("rst_cmd_addr", data_cmd_address, 0);
    reset_i = 1'b0;
    step();

    // Clean miss from reset, then a hit with no command
    push_cmd(27'h0000010, 1'b0, '0);
    exp_rsp.push_back(32'h00000000);
    issue(27'h0000010, 1'b0, 32'h0, 4'h0);
    check("fill_valid_n1", data_cmd_valid, 1);
    check("fill_write0", data_cmd_write, 0);
    ack_cmd(2);
    fill_rsp(l1);

    exp_rsp.push_back(32'h22222222);
    issue(27'h0000018, 1'b0, 32'h0, 4'h0);
    check("hit_rsp_n1", cpu_rsp_valid, 1);
    check("hit_no_cmd", data_cmd_valid, 0);
    step();

    // Partial-byte write hit, then read back
    exp_rsp.push_back(32'h11BB11DD);
    issue(27'h0000014, 1'b1, 32'hAABBCCDD, 4'b0101);
    check("wr_hit_rsp_n1", cpu_rsp_valid, 1);
    step();
    exp_rsp.push_back(32'h11BB11DD);
    issue(27'h0000014, 1'b0, 32'h0, 4'h0);
    check("rd_back_rsp_n1", cpu_rsp_valid, 1);
    step();
    check("cmd_count_after_hits", n_cmds, exp_n_cmds);

    // Dirty miss: write-back of merged line, then fill, back to back
    push_cmd(27'h0000010, 1'b1, l1m);
    push_cmd(27'h0000040, 1'b0, '0);
    exp_rsp.push_back(32'hA0A0A0A0);
    issue(27'h0000040, 1'b0, 32'h0, 4'h0);
    check("wb_valid_n1", data_cmd_valid, 1);
    check("wb_write1", data_cmd_write, 1);
    ack_cmd(0);
    check("fill_after_wb_valid", data_cmd_valid, 1);
    check("fill_after_wb_write", data_cmd_write, 0);
    check("fill_after_wb_addr", data_cmd_address, 27'h0000040);
    ack_cmd(1);
    fill_rsp(l2);
    check("cmd_count_after_dirty_miss", n_cmds, exp_n_cmds);

    exp_rsp.push_back(32'h12345678);
    issue(27'h0000048, 1'b1, 32'h12345678, 4'hF);
    step();

    // Dirty flush with the ack held off for five cycles
    push_cmd(27'h0000040, 1'b1, l2m);
    flush_i = 1'b1;
    #1 check("ready_low_during_flush", cpu_req_ready, 0);
    step();
    flush_i = 1'b0;
    check("flush_wb_valid", data_cmd_valid, 1);
    check("flush_wb_write", data_cmd_write, 1);
    check("flush_not_done_early", flush_done_o, 0);
    ack_cmd(5);
    check("flush_done_a1", flush_done_o, 1);
    step();
    check("flush_done_pulse", flush_done_o, 0);

    // After flush the line is invalid: plain fill, no write-back
    push_cmd(27'h0000040, 1'b0, '0);
    exp_rsp.push_back(32'h39393939);
    issue(27'h0000040, 1'b0, 32'h0, 4'h0);
    check("post_flush_fill_valid", data_cmd_valid, 1);
    check("post_flush_fill_write", data_cmd_write, 0);
    ack_cmd(0);
    fill_rsp(l3);

    // Reset while waiting for fill data, then a stray fill response
    push_cmd(27'h0000080, 1'b0, '0);
    issue(27'h0000080, 1'b0, 32'h0, 4'h0);
    ack_cmd(1);
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    check("reset_cmd_valid", data_cmd_valid, 0);
    data_rsp_data_i = l4;
    data_rsp_ready  = 1'b1;
    step();
    data_rsp_ready  = 1'b0;
    check("stray_rsp_ignored", cpu_rsp_valid, 0);
    step();
    check("stray_rsp_ignored_2", cpu_rsp_valid, 0);

    push_cmd(27'h0000080, 1'b0, '0);
    exp_rsp.push_back(32'h4A4A4A4A);
    issue(27'h0000080, 1'b0, 32'h0, 4'h0);
    check("refill_after_reset", data_cmd_valid, 1);
    ack_cmd(0);
    fill_rsp(l4);

    // Flush and request together on a clean line: flush wins, request next
    cpu_req_addr  = 27'h0000084;
    cpu_req_write = 1'b0;
    cpu_req_valid = 1'b1;
    flush_i       = 1'b1;
    #1 check("flush_wins_ready", cpu_req_ready, 0);
    step();
    flush_i = 1'b0;
    check("clean_flush_done_n1", flush_done_o, 1);
    #1 check("req_ready_after_flush", cpu_req_ready, 1);
    push_cmd(27'h0000080, 1'b0, '0);
    exp_rsp.push_back(32'h5B5B5B5B);
    step();
    cpu_req_valid = 1'b0;
    check("fill_after_clean_flush", data_cmd_valid, 1);
    ack_cmd(0);
    fill_rsp(l5);

    step();
    check("rsp_queue_drained", exp_rsp.size(), 0);
    check("cmd_queue_drained", exp_cmd.size(), 0);
    check("cmd_count_final", n_cmds, exp_n_cmds);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_sddr_line_buffer
